// File: rtl/apu_memory_responder.sv
// Memory responder for the APU instruction/data bus: serves level-held reads and
// writes from a local BRAM, forwards reads to system RAM, and accepts host BRAM loads.
module apu_memory_responder #(
    parameter int unsigned BRAM_DEPTH  = 256,
    parameter int unsigned RAM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] apuAddress,
    input  logic [15:0] apuWriteData,
    input  logic        apuWriteEnable,
    input  logic        apuReadEnable,
    input  logic        apuReadRAM,
    output logic [15:0] apuDataIn,
    output logic        apuDataReady,
    output logic        apuWriteAcknowledge,
    input  logic [7:0]  hostWriteAddress,
    input  logic [15:0] hostWriteData,
    input  logic        hostWriteEnable,
    output logic [31:0] ramAddress,
    output logic        ramRead,
    input  logic [15:0] ramReadData,
    input  logic        ramDone,
    output logic        ramTimeout
);
    localparam int unsigned ADDR_W = $clog2(BRAM_DEPTH);
    localparam int unsigned CNT_W  = $clog2(RAM_TIMEOUT + 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] BRAM_READ  = 3'd1;
    localparam logic [2:0] BRAM_WRITE = 3'd2;
    localparam logic [2:0] RAM_READ   = 3'd3;
    localparam logic [2:0] RESPOND    = 3'd4;

    logic [2:0]        state;
    logic [2:0]        stateNext;
    logic [ADDR_W-1:0] addrReg;
    logic [ADDR_W-1:0] addrRegNext;
    logic [15:0]       dataReg;
    logic [15:0]       dataRegNext;
    logic [CNT_W-1:0]  timeoutCount;
    logic [CNT_W-1:0]  timeoutCountNext;
    logic [15:0]       apuDataInNext;
    logic              apuDataReadyNext;
    logic              apuWriteAcknowledgeNext;
    logic              ramReadNext;
    logic [31:0]       ramAddressNext;
    logic              ramTimeoutNext;

    logic              apuWriteLand;
    logic [ADDR_W-1:0] apuWriteIndex;
    logic [15:0]       apuWriteValue;
    logic [ADDR_W-1:0] apuIndex;

    logic [15:0] bram [BRAM_DEPTH];

    assign apuIndex = apuAddress[ADDR_W-1:0];

    // Next-state, next-output and BRAM write-port selection
    always_comb begin
        stateNext               = state;
        addrRegNext             = addrReg;
        dataRegNext             = dataReg;
        timeoutCountNext        = timeoutCount;
        apuDataInNext           = apuDataIn;
        apuDataReadyNext        = 1'b0;
        apuWriteAcknowledgeNext = 1'b0;
        ramReadNext             = ramRead;
        ramAddressNext          = ramAddress;
        ramTimeoutNext          = ramTimeout;
        apuWriteLand            = 1'b0;
        apuWriteIndex           = addrReg;
        apuWriteValue           = dataReg;

        case (state)
            IDLE: begin
                if (apuWriteEnable) begin
                    addrRegNext = apuIndex;
                    dataRegNext = apuWriteData;
                    if (hostWriteEnable) begin
                        // Host owns this edge; retry the APU write next cycle
                        stateNext = BRAM_WRITE;
                    end else begin
                        apuWriteLand            = 1'b1;
                        apuWriteIndex           = apuIndex;
                        apuWriteValue           = apuWriteData;
                        apuWriteAcknowledgeNext = 1'b1;
                        stateNext               = RESPOND;
                    end
                end else if (apuReadEnable) begin
                    addrRegNext = apuIndex;
                    if (apuReadRAM) begin
                        ramReadNext      = 1'b1;
                        ramAddressNext   = apuAddress;
                        timeoutCountNext = '0;
                        stateNext        = RAM_READ;
                    end else begin
                        stateNext = BRAM_READ;
                    end
                end
            end
            BRAM_READ: begin
                apuDataInNext    = bram[addrReg];
                apuDataReadyNext = 1'b1;
                stateNext        = RESPOND;
            end
            BRAM_WRITE: begin
                apuWriteLand            = 1'b1;
                apuWriteAcknowledgeNext = 1'b1;
                stateNext               = RESPOND;
            end
            RAM_READ: begin
                if (ramDone) begin
                    apuDataInNext    = ramReadData;
                    ramReadNext      = 1'b0;
                    apuDataReadyNext = 1'b1;
                    stateNext        = RESPOND;
                end else if (timeoutCount == CNT_W'(RAM_TIMEOUT - 1)) begin
                    apuDataInNext    = 16'h0000;
                    ramReadNext      = 1'b0;
                    ramTimeoutNext   = 1'b1;
                    apuDataReadyNext = 1'b1;
                    stateNext        = RESPOND;
                end else begin
                    timeoutCountNext = timeoutCount + CNT_W'(1);
                end
            end
            RESPOND: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= IDLE;
            addrReg             <= '0;
            dataReg             <= '0;
            timeoutCount        <= '0;
            apuDataIn           <= 16'h0000;
            apuDataReady        <= 1'b0;
            apuWriteAcknowledge <= 1'b0;
            ramRead             <= 1'b0;
            ramAddress          <= 32'h0000_0000;
            ramTimeout          <= 1'b0;
        end else begin
            state               <= stateNext;
            addrReg             <= addrRegNext;
            dataReg             <= dataRegNext;
            timeoutCount        <= timeoutCountNext;
            apuDataIn           <= apuDataInNext;
            apuDataReady        <= apuDataReadyNext;
            apuWriteAcknowledge <= apuWriteAcknowledgeNext;
            ramRead             <= ramReadNext;
            ramAddress          <= ramAddressNext;
            ramTimeout          <= ramTimeoutNext;
        end
    end

    // Single BRAM write port: a landing APU write beats the host load
    always_ff @(posedge clk) begin
        if (rst_n && apuWriteLand) begin
            bram[apuWriteIndex] <= apuWriteValue;
        end else if (hostWriteEnable) begin
            bram[ADDR_W'(hostWriteAddress)] <= hostWriteData;
        end
    end

endmodule

// File: tb/tb_apu_memory_responder.sv
// Randomized self-checking bench for apu_memory_responder against a cycle-level
// transaction model of the BRAM/RAM responder.
module tb_apu_memory_responder;
    localparam int RAM_TIMEOUT = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] apuAddress;
    logic [15:0] apuWriteData;
    logic        apuWriteEnable;
    logic        apuReadEnable;
    logic        apuReadRAM;
    logic [15:0] apuDataIn;
    logic        apuDataReady;
    logic        apuWriteAcknowledge;
    logic [7:0]  hostWriteAddress;
    logic [15:0] hostWriteData;
    logic        hostWriteEnable;
    logic [31:0] ramAddress;
    logic        ramRead;
    logic [15:0] ramReadData;
    logic        ramDone;
    logic        ramTimeout;

    apu_memory_responder #(
        .BRAM_DEPTH (256),
        .RAM_TIMEOUT(RAM_TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .apuAddress         (apuAddress),
        .apuWriteData       (apuWriteData),
        .apuWriteEnable     (apuWriteEnable),
        .apuReadEnable      (apuReadEnable),
        .apuReadRAM         (apuReadRAM),
        .apuDataIn          (apuDataIn),
        .apuDataReady       (apuDataReady),
        .apuWriteAcknowledge(apuWriteAcknowledge),
        .hostWriteAddress   (hostWriteAddress),
        .hostWriteData      (hostWriteData),
        .hostWriteEnable    (hostWriteEnable),
        .ramAddress         (ramAddress),
        .ramRead            (ramRead),
        .ramReadData        (ramReadData),
        .ramDone            (ramDone),
        .ramTimeout         (ramTimeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: BRAM image and the outputs expected in the current cycle
    logic [15:0] mem [256];
    logic [15:0] expData;
    logic        expReady;
    logic        expAck;
    logic        expRamRead;
    logic [31:0] expRamAddr;
    logic        expTimeout;
    bit          checkEn;
    bit          hostRandOn;
    int          passCount;
    int          checkCount;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            passCount++;
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            check("apuDataIn", 32'(apuDataIn), 32'(expData));
            check("apuDataReady", 32'(apuDataReady), 32'(expReady));
            check("apuWriteAcknowledge", 32'(apuWriteAcknowledge), 32'(expAck));
            check("ramRead", 32'(ramRead), 32'(expRamRead));
            check("ramTimeout", 32'(ramTimeout), 32'(expTimeout));
            if (expRamRead) check("ramAddress", ramAddress, expRamAddr);
        end
    end

    task automatic hostNext();
        if (hostRandOn) begin
            hostWriteEnable  = ($urandom_range(0, 2) == 0);
            hostWriteAddress = 8'($urandom);
            hostWriteData    = 16'($urandom);
        end else begin
            hostWriteEnable = 1'b0;
        end
    endtask

    // Apply this cycle's BRAM update to the model, then advance one clock
    task automatic endCycle(input bit land, input logic [7:0] a, input logic [15:0] d);
        if (land) mem[a] = d;
        else if (hostWriteEnable) mem[hostWriteAddress] = hostWriteData;
        @(posedge clk);
        #1;
        hostNext();
    endtask

    task automatic bramRead(input logic [31:0] addr);
        logic [15:0] captured;
        apuReadEnable = 1'b1;
        apuReadRAM    = 1'b0;
        apuAddress    = addr;
        endCycle(1'b0, 8'h00, 16'h0000);
        captured = mem[addr[7:0]];
        endCycle(1'b0, 8'h00, 16'h0000);
        expReady = 1'b1;
        expData  = captured;
        endCycle(1'b0, 8'h00, 16'h0000);
        apuReadEnable = 1'b0;
        expReady      = 1'b0;
    endtask

    task automatic bramWrite(input logic [31:0] addr, input logic [15:0] data);
        bit collision;
        apuWriteEnable = 1'b1;
        apuReadEnable  = 1'($urandom);
        apuReadRAM     = 1'($urandom);
        apuAddress     = addr;
        apuWriteData   = data;
        collision      = hostWriteEnable;
        if (collision) begin
            endCycle(1'b0, 8'h00, 16'h0000);
            endCycle(1'b1, addr[7:0], data);
        end else begin
            endCycle(1'b1, addr[7:0], data);
        end
        expAck = 1'b1;
        endCycle(1'b0, 8'h00, 16'h0000);
        apuWriteEnable = 1'b0;
        apuReadEnable  = 1'b0;
        apuReadRAM     = 1'b0;
        expAck         = 1'b0;
    endtask

    // doneCycle 0 means RAM never answers
    task automatic ramReadTxn(input logic [31:0] addr, input int doneCycle, input logic [15:0] rdata);
        logic [15:0] result;
        bit timedOut;
        result        = 16'h0000;
        timedOut      = 1'b0;
        apuReadEnable = 1'b1;
        apuReadRAM    = 1'b1;
        apuAddress    = addr;
        ramDone       = 1'($urandom);
        ramReadData   = 16'($urandom);
        endCycle(1'b0, 8'h00, 16'h0000);
        for (int c = 1; c <= RAM_TIMEOUT; c++) begin
            expRamRead  = 1'b1;
            expRamAddr  = addr;
            ramDone     = (c == doneCycle);
            ramReadData = (c == doneCycle) ? rdata : 16'($urandom);
            if (c == doneCycle) result = rdata;
            endCycle(1'b0, 8'h00, 16'h0000);
            if (c == doneCycle) break;
            if (c == RAM_TIMEOUT) timedOut = 1'b1;
        end
        expRamRead = 1'b0;
        expReady   = 1'b1;
        expData    = timedOut ? 16'h0000 : result;
        if (timedOut) expTimeout = 1'b1;
        ramDone     = 1'($urandom);
        ramReadData = 16'($urandom);
        endCycle(1'b0, 8'h00, 16'h0000);
        apuReadEnable = 1'b0;
        apuReadRAM    = 1'b0;
        ramDone       = 1'b0;
        expReady      = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            ramDone     = 1'($urandom);
            ramReadData = 16'($urandom);
            endCycle(1'b0, 8'h00, 16'h0000);
        end
        ramDone = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        apuAddress = '0; apuWriteData = '0; apuWriteEnable = 1'b0; apuReadEnable = 1'b0;
        apuReadRAM = 1'b0; hostWriteAddress = '0; hostWriteData = '0; hostWriteEnable = 1'b0;
        ramReadData = '0; ramDone = 1'b0;
        expData = 16'h0000; expReady = 1'b0; expAck = 1'b0; expRamRead = 1'b0;
        expRamAddr = '0; expTimeout = 1'b0;
        checkEn = 1'b0; hostRandOn = 1'b0; passCount = 0; checkCount = 0;

        repeat (2) @(posedge clk);
        #1;
        checkEn = 1'b1;
        check("resetRamAddress", ramAddress, 32'h0000_0000);
        endCycle(1'b0, 8'h00, 16'h0000);
        rst_n = 1'b1;

        // Give every BRAM word a known value
        for (int i = 0; i < 256; i++) begin
            hostWriteEnable  = 1'b1;
            hostWriteAddress = 8'(i);
            hostWriteData    = 16'($urandom);
            endCycle(1'b0, 8'h00, 16'h0000);
        end

        hostWriteEnable = 1'b1; hostWriteAddress = 8'd5; hostWriteData = 16'h00A3;
        endCycle(1'b0, 8'h00, 16'h0000);
        bramRead(32'd5);
        check("readHostLoaded", 32'(apuDataIn), 32'h0000_00A3);

        bramWrite(32'h0000_0107, 16'h1234);
        bramRead(32'd7);
        check("writeWrapRead", 32'(apuDataIn), 32'h0000_1234);

        hostWriteEnable = 1'b1; hostWriteAddress = 8'd9; hostWriteData = 16'hBEEF;
        bramWrite(32'd9, 16'h5A5A);
        bramRead(32'd9);
        check("collisionApuWins", 32'(apuDataIn), 32'h0000_5A5A);

        ramReadTxn(32'h0001_0000, 4, 16'h7F00);
        check("ramReadData", 32'(apuDataIn), 32'h0000_7F00);

        ramReadTxn(32'h0000_0040, 0, 16'h0000);
        check("timeoutFlag", 32'(ramTimeout), 32'h1);
        ramDone = 1'b1; ramReadData = 16'hFFFF;
        endCycle(1'b0, 8'h00, 16'h0000);
        ramDone = 1'b0;
        endCycle(1'b0, 8'h00, 16'h0000);
        check("lateDoneIgnored", 32'(apuDataIn), 32'h0000_0000);

        // Reset during cycle 2 of a RAM read
        apuReadEnable = 1'b1; apuReadRAM = 1'b1; apuAddress = 32'h0000_2000;
        endCycle(1'b0, 8'h00, 16'h0000);
        expRamRead = 1'b1; expRamAddr = 32'h0000_2000;
        endCycle(1'b0, 8'h00, 16'h0000);
        rst_n = 1'b0;
        endCycle(1'b0, 8'h00, 16'h0000);
        rst_n = 1'b1; apuReadEnable = 1'b0; apuReadRAM = 1'b0;
        expRamRead = 1'b0; expData = 16'h0000; expTimeout = 1'b0; expReady = 1'b0;
        check("rstRamRead", 32'(ramRead), 32'h0);
        check("rstRamAddress", ramAddress, 32'h0000_0000);
        check("rstTimeout", 32'(ramTimeout), 32'h0);
        endCycle(1'b0, 8'h00, 16'h0000);
        bramRead(32'd9);
        check("afterResetRead", 32'(apuDataIn), 32'h0000_5A5A);

        // Randomized traffic with background host loads
        hostRandOn = 1'b1;
        hostNext();
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 2))
                0: bramRead($urandom);
                1: bramWrite($urandom, 16'($urandom));
                default: ramReadTxn($urandom, int'($urandom_range(0, RAM_TIMEOUT)), 16'($urandom));
            endcase
            if ($urandom_range(0, 1) == 1) idleCycles(int'($urandom_range(1, 3)));
        end
        hostRandOn = 1'b0;
        hostNext();
        idleCycles(2);
        checkEn = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
